// File: rtl/branch_predict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl_pkg
// Description : Shared widths, FSM states and 2-bit counter helpers for the
//               branch prediction controller.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_predict_ctrl_pkg;

   localparam int PATTERN_WIDTH  = 4;
   localparam int INST_MEM_WIDTH = 16;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      FLUSH = 2'd2,
      DRAIN = 2'd3
   } bp_state_t;

   localparam logic [1:0] ST_INIT  = INIT;
   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_FLUSH = FLUSH;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   localparam logic [1:0] SAT_MIN = 2'b00;
   localparam logic [1:0] WEAK_NT = 2'b01;
   localparam logic [1:0] SAT_MAX = 2'b11;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == SAT_MAX) ? SAT_MAX : ctr + 2'd1;
      end
      return (ctr == SAT_MIN) ? SAT_MIN : ctr - 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_pht_ram.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl_pht_ram
// Description : Pattern history table of 2-bit counters. One registered read
//               port, one read-modify-write port with write-forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl_pht_ram
   import branch_predict_ctrl_pkg::*;
#(
   parameter int PHT_WIDTH = 10
) (
   input  logic                 clk,
   input  logic [PHT_WIDTH-1:0] rd_idx,
   output logic [1:0]           rd_fwd,
   output logic [1:0]           rd_data,
   input  logic                 wr_en,
   input  logic                 wr_init,
   input  logic                 wr_taken,
   input  logic [PHT_WIDTH-1:0] wr_idx
);

   localparam int DEPTH = 2 ** PHT_WIDTH;

   logic [1:0] mem_q [0:DEPTH-1];
   logic [1:0] wr_data;
   logic [1:0] rd_data_d;
   logic [1:0] rd_data_q;

   // rd_fwd exposes the post-write value the same cycle so the top can shift it into the GHR
   always_comb begin
      wr_data   = wr_init ? WEAK_NT : sat_update(mem_q[wr_idx], wr_taken);
      rd_data_d = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem_q[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_fwd  = rd_data_d;
   assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_ctrl
// Description : gshare prediction, PHT training, PHT initialisation and
//               misprediction recovery (flush/redirect/drain) sequencer.
//               Optional BRANCH_STATS_EN adds commit/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl
   import branch_predict_ctrl_pkg::*;
#(
   parameter int PHT_WIDTH    = 10,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      lookup_valid,
   input  logic [INST_MEM_WIDTH-1:0] lookup_pc,
   output logic                      pred_valid,
   output logic [1:0]                prediction_begin,
   output logic [PATTERN_WIDTH-1:0]  pattern_begin,
   input  logic                      commit,
   input  logic                      failure,
   input  logic [1:0]                prediction_end,
   input  logic [PATTERN_WIDTH-1:0]  pattern_end,
   input  logic [INST_MEM_WIDTH-1:0] commit_pc,
   input  logic [INST_MEM_WIDTH-1:0] addr_on_failure,
   output logic                      flush,
   output logic                      redirect_valid,
   output logic [INST_MEM_WIDTH-1:0] redirect_pc,
   output logic                      fetch_stall
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]               stat_commits,
   output logic [31:0]               stat_mispredicts
`endif
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCW-1:0] DRAIN_LOAD = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

   logic [1:0]                state_d, state_q;
   logic [PHT_WIDTH-1:0]      init_idx_d, init_idx_q;
   logic [DCW-1:0]            drain_cnt_d, drain_cnt_q;
   logic [PATTERN_WIDTH-1:0]  ghr_d, ghr_q;
   logic                      pred_valid_d, pred_valid_q;
   logic [PATTERN_WIDTH-1:0]  pattern_begin_d, pattern_begin_q;
   logic [INST_MEM_WIDTH-1:0] redirect_pc_d, redirect_pc_q;

   logic                 in_init;
   logic                 accept_commit;
   logic                 mispredict;
   logic                 taken;
   logic [PHT_WIDTH-1:0] lookup_idx;
   logic [PHT_WIDTH-1:0] update_idx;
   logic                 pht_wr_en;
   logic [PHT_WIDTH-1:0] pht_wr_idx;
   logic [1:0]           pht_rd_fwd;
   logic [1:0]           pht_rd_data;
   logic                 unused_bits;

   assign in_init       = (state_q == ST_INIT);
   assign accept_commit = (state_q == ST_IDLE) && commit;
   assign mispredict    = accept_commit && failure;
   assign taken         = failure ^ prediction_end[1];
   assign lookup_idx    = lookup_pc[PHT_WIDTH-1:0] ^ PHT_WIDTH'(ghr_q);
   assign update_idx    = commit_pc[PHT_WIDTH-1:0] ^ PHT_WIDTH'(pattern_end);
   assign pht_wr_en     = !reset && (in_init || accept_commit);
   assign pht_wr_idx    = in_init ? init_idx_q : update_idx;
   assign unused_bits   = ^{lookup_pc, commit_pc, prediction_end};

   branch_predict_ctrl_pht_ram #(
      .PHT_WIDTH (PHT_WIDTH)
   ) u_pht (
      .clk      (clk),
      .rd_idx   (lookup_idx),
      .rd_fwd   (pht_rd_fwd),
      .rd_data  (pht_rd_data),
      .wr_en    (pht_wr_en),
      .wr_init  (in_init),
      .wr_taken (taken),
      .wr_idx   (pht_wr_idx)
   );

   always_comb begin
      state_d         = state_q;
      init_idx_d      = init_idx_q;
      drain_cnt_d     = drain_cnt_q;
      ghr_d           = ghr_q;
      pred_valid_d    = 1'b0;
      pattern_begin_d = pattern_begin_q;
      redirect_pc_d   = redirect_pc_q;
      case (state_q)
         ST_INIT: begin
            init_idx_d = init_idx_q + PHT_WIDTH'(1);
            if (init_idx_q == '1) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A mispredict owns the GHR write and drops any same-cycle lookup
            if (mispredict) begin
               ghr_d         = {pattern_end[PATTERN_WIDTH-2:0], taken};
               redirect_pc_d = addr_on_failure;
               state_d       = ST_FLUSH;
            end else if (lookup_valid) begin
               pred_valid_d    = 1'b1;
               pattern_begin_d = ghr_q;
               ghr_d           = {ghr_q[PATTERN_WIDTH-2:0], pht_rd_fwd[1]};
            end
         end
         ST_FLUSH: begin
            if (DRAIN_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q - DCW'(1);
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_INIT;
         init_idx_q      <= '0;
         drain_cnt_q     <= '0;
         ghr_q           <= '0;
         pred_valid_q    <= 1'b0;
         pattern_begin_q <= '0;
         redirect_pc_q   <= '0;
      end else begin
         state_q         <= state_d;
         init_idx_q      <= init_idx_d;
         drain_cnt_q     <= drain_cnt_d;
         ghr_q           <= ghr_d;
         pred_valid_q    <= pred_valid_d;
         pattern_begin_q <= pattern_begin_d;
         redirect_pc_q   <= redirect_pc_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign prediction_begin = pht_rd_data;
   assign pattern_begin    = pattern_begin_q;
   assign flush            = (state_q == ST_FLUSH);
   assign redirect_valid   = (state_q == ST_FLUSH);
   assign redirect_pc      = redirect_pc_q;
   assign fetch_stall      = (state_q != ST_IDLE);

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_commits_d, stat_commits_q;
   logic [31:0] stat_mispredicts_d, stat_mispredicts_q;

   always_comb begin
      stat_commits_d     = stat_commits_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (accept_commit && (stat_commits_q != '1)) begin
         stat_commits_d = stat_commits_q + 32'd1;
      end
      if (mispredict && (stat_mispredicts_q != '1)) begin
         stat_mispredicts_d = stat_mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_commits_q     <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_commits_q     <= stat_commits_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_commits     = stat_commits_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_ctrl
// Description : Table-driven, hand-sequenced and randomized checks of
//               branch_predict_ctrl against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;
   import branch_predict_ctrl_pkg::*;

   localparam int PW      = 4;
   localparam int DC      = 2;
   localparam int ENTRIES = 2 ** PW;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid;
   logic [15:0] lookup_pc;
   logic        pred_valid;
   logic [1:0]  prediction_begin;
   logic [3:0]  pattern_begin;
   logic        commit;
   logic        failure;
   logic [1:0]  prediction_end;
   logic [3:0]  pattern_end;
   logic [15:0] commit_pc;
   logic [15:0] addr_on_failure;
   logic        flush;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        fetch_stall;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_commits;
   logic [31:0] stat_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_predict_ctrl #(
      .PHT_WIDTH    (PW),
      .DRAIN_CYCLES (DC)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .lookup_valid     (lookup_valid),
      .lookup_pc        (lookup_pc),
      .pred_valid       (pred_valid),
      .prediction_begin (prediction_begin),
      .pattern_begin    (pattern_begin),
      .commit           (commit),
      .failure          (failure),
      .prediction_end   (prediction_end),
      .pattern_end      (pattern_end),
      .commit_pc        (commit_pc),
      .addr_on_failure  (addr_on_failure),
      .flush            (flush),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .fetch_stall      (fetch_stall)
`ifdef BRANCH_STATS_EN
      ,
      .stat_commits     (stat_commits),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: counters as plain ints, recovery as a remaining-cycle count
   int          m_pht [ENTRIES];
   int          m_ghr;
   int          m_init_left;
   int          m_recover_left;
   bit          m_pv;
   int          m_pred;
   int          m_pat;
   int          m_rpc;
   int unsigned m_sc;
   int unsigned m_sm;

   typedef struct {
      logic        lv;
      logic [15:0] lpc;
      logic        cm;
      logic        fl;
      logic [1:0]  pe;
      logic [3:0]  pat;
      logic [15:0] cpc;
      logic [15:0] aof;
      logic        e_pv;
      logic [1:0]  e_pred;
      logic [3:0]  e_pat;
      logic        e_flush;
      logic        e_stall;
      logic [15:0] e_rpc;
   } vec_t;

   vec_t tbl [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_idle();
      lookup_valid    = 1'b0;
      lookup_pc       = '0;
      commit          = 1'b0;
      failure         = 1'b0;
      prediction_end  = '0;
      pattern_end     = '0;
      commit_pc       = '0;
      addr_on_failure = '0;
   endtask

   task automatic model_edge();
      int  u;
      int  lidx;
      bit  tk;
      if (reset) begin
         m_init_left    = ENTRIES;
         m_recover_left = 0;
         m_pv           = 1'b0;
         m_ghr          = 0;
         m_rpc          = 0;
         m_sc           = 0;
         m_sm           = 0;
      end else if (m_init_left > 0) begin
         m_pht[ENTRIES - m_init_left] = 1;
         m_init_left--;
         m_pv = 1'b0;
      end else if (m_recover_left > 0) begin
         m_recover_left--;
         m_pv = 1'b0;
      end else begin
         tk = failure ^ prediction_end[1];
         if (commit) begin
            u = (int'(commit_pc) ^ int'(pattern_end)) & (ENTRIES - 1);
            m_pht[u] = tk ? ((m_pht[u] == 3) ? 3 : m_pht[u] + 1)
                          : ((m_pht[u] == 0) ? 0 : m_pht[u] - 1);
            if (m_sc != 32'hFFFF_FFFF) m_sc++;
            if (failure && m_sm != 32'hFFFF_FFFF) m_sm++;
         end
         lidx = (int'(lookup_pc) ^ m_ghr) & (ENTRIES - 1);
         if (commit && failure) begin
            m_ghr          = ((int'(pattern_end) << 1) | int'(tk)) & 15;
            m_pv           = 1'b0;
            m_recover_left = 1 + DC;
            m_rpc          = int'(addr_on_failure);
         end else if (lookup_valid) begin
            m_pv   = 1'b1;
            m_pred = m_pht[lidx];
            m_pat  = m_ghr;
            m_ghr  = ((m_ghr << 1) | (m_pred >> 1)) & 15;
         end else begin
            m_pv = 1'b0;
         end
      end
   endtask

   task automatic step();
      bit exp_flush;
      model_edge();
      @(posedge clk);
      #1;
      exp_flush = (m_recover_left == 1 + DC);
      check("pred_valid", 32'(pred_valid), 32'(m_pv));
      if (m_pv) begin
         check("prediction_begin", 32'(prediction_begin), m_pred);
         check("pattern_begin", 32'(pattern_begin), m_pat);
      end
      check("flush", 32'(flush), 32'(exp_flush));
      check("redirect_valid", 32'(redirect_valid), 32'(exp_flush));
      if (exp_flush) check("redirect_pc", 32'(redirect_pc), m_rpc);
      check("fetch_stall", 32'(fetch_stall), 32'((m_init_left > 0) || (m_recover_left > 0)));
`ifdef BRANCH_STATS_EN
      check("stat_commits", stat_commits, m_sc);
      check("stat_mispredicts", stat_mispredicts, m_sm);
`endif
   endtask

   initial begin
      int stall_cycles;

      // Starts right after init: all counters 01, GHR 0
      //              lv   lpc       cm   fl   pe     pat      cpc      aof        pv   pred   pat      fl   st   rpc
      tbl[0]  = '{1'b1, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b1, 2'b01, 4'h0, 1'b0, 1'b0, 16'h0};
      tbl[1]  = '{1'b0, 16'h0, 1'b1, 1'b1, 2'b01, 4'h0, 16'h5, 16'h1234, 1'b0, 2'b00, 4'h0, 1'b1, 1'b1, 16'h1234};
      tbl[2]  = '{1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 16'h0};
      tbl[3]  = '{1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 16'h0};
      tbl[4]  = '{1'b0, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b0, 2'b00, 4'h0, 1'b0, 1'b0, 16'h0};
      tbl[5]  = tbl[1];
      tbl[6]  = tbl[2];
      tbl[7]  = tbl[3];
      tbl[8]  = tbl[4];
      tbl[9]  = tbl[1];
      tbl[10] = tbl[2];
      tbl[11] = tbl[3];
      tbl[12] = tbl[4];
      // GHR is now 0001, so pc=4 lands on index 5 (saturated at 11)
      tbl[13] = '{1'b1, 16'h4, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b1, 2'b11, 4'h1, 1'b0, 1'b0, 16'h0};
      // Same-cycle taken commit and lookup at index 3: forwarded 10
      tbl[14] = '{1'b1, 16'h0, 1'b1, 1'b0, 2'b10, 4'h0, 16'h3, 16'h0,    1'b1, 2'b10, 4'h3, 1'b0, 1'b0, 16'h0};
      // Mispredict with lookup: lookup dropped, GHR <= 0111
      tbl[15] = '{1'b1, 16'h5, 1'b1, 1'b1, 2'b00, 4'h3, 16'h0, 16'h0abc, 1'b0, 2'b00, 4'h0, 1'b1, 1'b1, 16'h0abc};
      tbl[16] = tbl[2];
      tbl[17] = tbl[3];
      tbl[18] = tbl[4];
      tbl[19] = '{1'b1, 16'h0, 1'b0, 1'b0, 2'b00, 4'h0, 16'h0, 16'h0,    1'b1, 2'b01, 4'h7, 1'b0, 1'b0, 16'h0};

      // Reset and INIT duration
      drive_idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      stall_cycles = fetch_stall ? 1 : 0;
      for (int i = 0; i < ENTRIES + 2; i++) begin
         step();
         if (fetch_stall) stall_cycles++;
      end
      check("init_stall_cycles", stall_cycles, ENTRIES);

      for (int i = 0; i < 20; i++) begin
         lookup_valid    = tbl[i].lv;
         lookup_pc       = tbl[i].lpc;
         commit          = tbl[i].cm;
         failure         = tbl[i].fl;
         prediction_end  = tbl[i].pe;
         pattern_end     = tbl[i].pat;
         commit_pc       = tbl[i].cpc;
         addr_on_failure = tbl[i].aof;
         step();
         check($sformatf("tbl%0d_pred_valid", i), 32'(pred_valid), 32'(tbl[i].e_pv));
         if (tbl[i].e_pv) begin
            check($sformatf("tbl%0d_prediction", i), 32'(prediction_begin), 32'(tbl[i].e_pred));
            check($sformatf("tbl%0d_pattern", i), 32'(pattern_begin), 32'(tbl[i].e_pat));
         end
         check($sformatf("tbl%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
         check($sformatf("tbl%0d_redirect_valid", i), 32'(redirect_valid), 32'(tbl[i].e_flush));
         if (tbl[i].e_flush) check($sformatf("tbl%0d_redirect_pc", i), 32'(redirect_pc), 32'(tbl[i].e_rpc));
         check($sformatf("tbl%0d_fetch_stall", i), 32'(fetch_stall), 32'(tbl[i].e_stall));
      end

      // Reset asserted during DRAIN
      drive_idle();
      commit          = 1'b1;
      failure         = 1'b1;
      commit_pc       = 16'h9;
      addr_on_failure = 16'h0042;
      step();
      drive_idle();
      step();
      reset = 1'b1;
      step();
      check("rst_drain_flush", 32'(flush), 32'h0);
      check("rst_drain_redirect_valid", 32'(redirect_valid), 32'h0);
      check("rst_drain_fetch_stall", 32'(fetch_stall), 32'h1);
`ifdef BRANCH_STATS_EN
      check("rst_drain_stat_commits", stat_commits, 32'h0);
`endif
      reset = 1'b0;
      stall_cycles = fetch_stall ? 1 : 0;
      for (int i = 0; i < ENTRIES + 2; i++) begin
         step();
         if (fetch_stall) stall_cycles++;
      end
      check("reinit_stall_cycles", stall_cycles, ENTRIES);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         reset           = ($urandom_range(0, 299) == 0);
         lookup_valid    = $urandom_range(0, 1) == 1;
         lookup_pc       = 16'($urandom_range(0, 31));
         commit          = $urandom_range(0, 2) == 0;
         failure         = $urandom_range(0, 3) == 0;
         prediction_end  = 2'($urandom);
         pattern_end     = 4'($urandom);
         commit_pc       = 16'($urandom);
         addr_on_failure = 16'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
